// File: rtl/dot_collect.sv
// dot_collect: collects scalar dot-product results into 8x8 ping-pong banks
//   and emits each completed block as eight 8-element vectors.
// Latency: dout_valid rises the cycle after the 64th sample of a block.
// Backpressure: none toward upstream (din is dropped and overflow is set
//   when the write bank is still full); downstream uses dout_valid/dout_ready.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   din, din_valid      one DW-bit float sample per valid cycle
//   dout[7:0]           current output vector (combinational from read bank)
//   dout_valid          read bank holds a complete block
//   dout_ready          downstream takes dout this cycle
//   dout_last           dout is the eighth vector of the block
//   overflow            sticky: a sample was dropped since reset
//
// Build option: define DOT_COLLECT_TRANSPOSE_EN to read the block out
//   column-major (transposed) instead of row-major.

module dot_collect #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout [7:0],
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic          dout_last,
  output logic          overflow
);

  // Per-bank state encoding: each bank is EMPTY or FULL.
  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  // Sample storage: address = {bank, row, col}.
  logic [DW-1:0] mem_q [128];

  // Control state.
  logic [1:0] full_q, full_d;     // per-bank FSM state
  logic [5:0] wcnt_q, wcnt_d;     // write index within the write bank
  logic [2:0] rcnt_q, rcnt_d;     // vector index within the read bank
  logic       wbank_q, wbank_d;   // bank currently being filled
  logic       rbank_q, rbank_d;   // bank currently being read
  logic       ovf_q, ovf_d;       // sticky drop flag

  // Handshake / event decode.
  logic wr_en;    // sample accepted this cycle
  logic wr_done;  // this accept is the 64th of the bank
  logic rd_fire;  // vector handshake this cycle
  logic rd_done;  // this handshake is the 8th vector of the bank

  // A sample is accepted only if the write bank was EMPTY at the start of
  // the cycle. A bank that finishes its readout this cycle was FULL going
  // in, so its final read frees it for the next cycle, not this one.
  assign wr_en   = din_valid & (full_q[wbank_q] == EMPTY);
  assign wr_done = wr_en & (wcnt_q == 6'd63);
  assign rd_fire = (full_q[rbank_q] == FULL) & dout_ready;
  assign rd_done = rd_fire & (rcnt_q == 3'd7);

  //--------------------------------------------------------------------------
  // State register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q  <= {EMPTY, EMPTY};
      wcnt_q  <= 6'd0;
      rcnt_q  <= 3'd0;
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      full_q  <= full_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      ovf_q   <= ovf_d;
    end
  end

  // Bank storage carries no reset; contents are qualified by full_q.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[{wbank_q, wcnt_q}] <= din;
    end
  end

  //--------------------------------------------------------------------------
  // Next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    full_d  = full_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    wbank_d = wbank_q;
    rbank_d = rbank_q;
    ovf_d   = ovf_q;

    // Write side: wcnt wraps naturally from 63 to 0.
    if (wr_en) begin
      wcnt_d = wcnt_q + 6'd1;
    end
    if (wr_done) begin
      full_d[wbank_q] = FULL;
      wbank_d         = ~wbank_q;
    end

    // Read side. wr_done needs the write bank EMPTY and rd_done needs the
    // read bank FULL, so when both fire they address different banks and
    // both updates land.
    if (rd_fire) begin
      rcnt_d = rcnt_q + 3'd1;
    end
    if (rd_done) begin
      full_d[rbank_q] = EMPTY;
      rbank_d         = ~rbank_q;
    end

    // Any sample arriving against a FULL write bank is lost.
    if (din_valid && (full_q[wbank_q] == FULL)) begin
      ovf_d = 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Output logic
  //--------------------------------------------------------------------------
  always_comb begin
    dout_valid = (full_q[rbank_q] == FULL);
    dout_last  = dout_valid & (rcnt_q == 3'd7);
    overflow   = ovf_q;
  end

  // dout depends only on registered state, so it is stable while stalled.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
`ifdef DOT_COLLECT_TRANSPOSE_EN
      dout[k] = mem_q[{rbank_q, 3'(k), rcnt_q}];
`else
      dout[k] = mem_q[{rbank_q, rcnt_q, 3'(k)}];
`endif
    end
  end

endmodule

// File: tb/tb_dot_collect.sv
// Directed bench for dot_collect: basic block, backpressure, streaming,
// same-cycle bank swap, overflow, and mid-operation reset.
`timescale 1ns/1ps

module tb_dot_collect;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        din_valid;
  logic [31:0] dout [7:0];
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        overflow;

  int n_vec;
  int n_miss;
  int nv;

  dot_collect #(.DW(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_last (dout_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-precision encoding of a small non-negative integer.
  function automatic logic [31:0] f2b(input int n);
    int          e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 24; b++) if (n >= (1 << b)) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // Sample index expected at element k of vector v in a block whose first
  // sample had index base.
  function automatic int exp_el(input int base, input int v, input int k);
`ifdef DOT_COLLECT_TRANSPOSE_EN
    return base + k * 8 + v;
`else
    return base + v * 8 + k;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input int base, input int v);
    check({tag, "_vld"}, {31'b0, dout_valid}, 32'd1);
    check({tag, "_last"}, {31'b0, dout_last}, (v == 7) ? 32'd1 : 32'd0);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_v%0d_e%0d", tag, v, k), dout[k], f2b(exp_el(base, v, k)));
  endtask

  // Present n consecutive samples base..base+n-1, one per cycle.
  task automatic fill(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      din       = f2b(base + i);
      din_valid = 1'b1;
      step();
    end
    din_valid = 1'b0;
  endtask

  // Check and transfer vectors v0..v1 (caller holds dout_ready=1).
  task automatic drain(input string tag, input int base, input int v0, input int v1);
    for (int v = v0; v <= v1; v++) begin
      chk_vec(tag, base, v);
      step();
    end
  endtask

  task automatic do_reset(input string tag);
    din_valid = 1'b0;
    rst       = 1'b1;
    #2;
    check({tag, "_in_vld"},  {31'b0, dout_valid}, 32'd0);
    check({tag, "_in_last"}, {31'b0, dout_last},  32'd0);
    check({tag, "_in_ovf"},  {31'b0, overflow},   32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    check({tag, "_out_vld"}, {31'b0, dout_valid}, 32'd0);
    check({tag, "_out_ovf"}, {31'b0, overflow},   32'd0);
  endtask

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;

    // Basic block: 0..63, downstream always ready.
    dout_ready = 1'b1;
    do_reset("t1_rst");
    fill(0, 63);
    check("t1_pre_vld", {31'b0, dout_valid}, 32'd0);
    fill(63, 1);
    drain("t1", 0, 0, 7);
    check("t1_post_vld", {31'b0, dout_valid}, 32'd0);

    // Backpressure: stall 20 cycles on vector 3.
    dout_ready = 1'b0;
    do_reset("t2_rst");
    fill(0, 64);
    dout_ready = 1'b1;
    drain("t2a", 0, 0, 2);
    dout_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      chk_vec("t2_stall", 0, 3);
      step();
    end
    check("t2_rcnt", {29'b0, dut.rcnt_q}, 32'd3);
    dout_ready = 1'b1;
    drain("t2b", 0, 3, 7);
    check("t2_post_vld", {31'b0, dout_valid}, 32'd0);

    // Streaming: 192 back-to-back samples, banks 0,1,0.
    dout_ready = 1'b1;
    do_reset("t3_rst");
    nv = 0;
    fork
      fill(200, 192);
      begin
        for (int c = 0; c < 300 && nv < 24; c++) begin
          @(negedge clk);
          if (dout_valid && dout_ready) begin
            chk_vec("t3", 200 + (nv / 8) * 64, nv % 8);
            check("t3_bank", {31'b0, dut.rbank_q}, 32'((nv / 8) % 2));
            nv++;
          end
        end
      end
    join
    check("t3_count", nv, 32'd24);
    check("t3_ovf", {31'b0, overflow}, 32'd0);

    // Same cycle: last write into bank 1 with final handshake of bank 0.
    dout_ready = 1'b0;
    do_reset("t5_rst");
    fill(0, 64);
    fill(64, 56);
    for (int i = 0; i < 8; i++) begin
      din        = f2b(120 + i);
      din_valid  = 1'b1;
      dout_ready = 1'b1;
      chk_vec("t5_b0", 0, i);
      step();
    end
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    check("t5_vld",  {31'b0, dout_valid}, 32'd1);
    check("t5_full", {30'b0, dut.full_q}, 32'd2);
    check("t5_rb",   {31'b0, dut.rbank_q}, 32'd1);
    check("t5_ovf",  {31'b0, overflow}, 32'd0);
    dout_ready = 1'b1;
    drain("t5_b1", 64, 0, 7);
    check("t5_post_vld", {31'b0, dout_valid}, 32'd0);

    // Overflow: 129 samples with downstream stalled.
    dout_ready = 1'b0;
    do_reset("t4_rst");
    fill(0, 128);
    check("t4_ovf_pre", {31'b0, overflow}, 32'd0);
    fill(128, 1);
    check("t4_ovf_set", {31'b0, overflow}, 32'd1);
    for (int c = 0; c < 5; c++) step();
    check("t4_ovf_hold", {31'b0, overflow}, 32'd1);
    dout_ready = 1'b1;
    drain("t4_blk1", 0, 0, 7);
    drain("t4_blk2", 64, 0, 7);
    check("t4_post_vld", {31'b0, dout_valid}, 32'd0);
    check("t4_ovf_end",  {31'b0, overflow}, 32'd1);

    // Reset mid-operation after 40 samples (overflow still set from above).
    dout_ready = 1'b1;
    fill(400, 40);
    do_reset("t6_rst");
    fill(300, 63);
    check("t6_pre_vld", {31'b0, dout_valid}, 32'd0);
    fill(363, 1);
    drain("t6", 300, 0, 7);
    check("t6_post_vld", {31'b0, dout_valid}, 32'd0);
    check("t6_ovf", {31'b0, overflow}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/dot_collect.md
DOT_COLLECT -- requirements
Module: dot_collect

Interface
REQ-001 SHALL have parameter DW, default 32, the width of one single-precision float word.
REQ-002 SHALL have port clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port din  input  DW  one scalar dot-product result from the upstream dot-product stage.
REQ-005 SHALL have port din_valid  input  1  din is valid this cycle; there is no backpressure toward upstream.
REQ-006 SHALL have port dout  output  DW x 8 (unpacked [7:0])  one assembled 8-element vector.
REQ-007 SHALL have port dout_valid  output  1  dout holds a valid vector.
REQ-008 SHALL have port dout_ready  input  1  downstream accepts dout this cycle.
REQ-009 SHALL have port dout_last  output  1  dout is vector 7 of the current 8x8 block.
REQ-010 SHALL have port overflow  output  1  sticky flag: an input sample was dropped.

Function
REQ-011 SHALL store samples in two 64-word banks (ping-pong), bank 0 filled first after reset.
REQ-012 SHALL write each sample with din_valid=1 into the active write bank at index wcnt (0..63), row-major: row = wcnt[5:3], col = wcnt[2:0].
REQ-013 SHALL increment wcnt on each accepted sample; on the 64th sample (wcnt=63) SHALL set that bank's FULL flag, wrap wcnt to 0, and toggle the write bank.
REQ-014 SHALL treat each bank as a two-state FSM: EMPTY -> FULL on its 64th write, FULL -> EMPTY on the handshake of its 8th output vector.
REQ-015 SHALL drop any sample arriving while the write bank is FULL: no write, wcnt is held, and overflow is set and held until reset.
REQ-016 SHALL drive dout_valid = FULL flag of the read bank, so dout_valid rises the cycle after the 64th write; input-to-first-output latency is 1 cycle.
REQ-017 SHALL drive dout combinationally from the read bank at read index rcnt (0..7); for row readout, dout[k] = element(row=rcnt, col=k).
REQ-018 SHALL advance rcnt only on dout_valid & dout_ready; a transfer of rcnt=7 wraps rcnt to 0, clears that bank's FULL flag, and toggles the read bank.
REQ-019 SHALL drive dout_last = dout_valid & (rcnt==7).
REQ-020 SHALL hold dout and dout_last stable while dout_valid=1 and dout_ready=0.
REQ-021 SHALL handle a bank reaching FULL and the other bank's final read handshake in the same cycle: both flag updates take effect, with no lost sample and no lost vector.
REQ-022 SHALL accept a write into a bank whose final read handshake completes in the same cycle, provided that bank was EMPTY before the cycle; otherwise the sample is dropped per REQ-015.
REQ-023 SHALL sustain one input per cycle indefinitely when downstream accepts at least 8 vectors per 64 cycles.

Reset
REQ-024 SHALL, on rst=1, asynchronously clear wcnt, rcnt, both FULL flags, both bank pointers (to 0), and overflow.
REQ-025 SHALL, during reset and immediately after it, drive dout_valid=0, dout_last=0, and overflow=0; dout and bank contents are don't-care.
REQ-026 SHALL discard any partially filled or partially read block when reset is asserted mid-operation.

Configuration
REQ-027 SHALL, when macro DOT_COLLECT_TRANSPOSE_EN is defined, read out column-major: dout[k] = element(row=k, col=rcnt), delivering the transposed block for the second 1-D DCT pass.
REQ-028 SHALL, when DOT_COLLECT_TRANSPOSE_EN is undefined, read out row-major per REQ-017; write order, latency, and handshake behaviour are identical in both builds.

Verification
REQ-029 SHALL cover the basic case: 64 consecutive samples with din = index float (0.0 .. 63.0) and dout_ready=1 -> dout_valid rises 1 cycle after the last sample; vector 0 = 0.0..7.0 (transposed build: 0.0, 8.0, .. 56.0); dout_last is set on vector 7.
REQ-030 SHALL cover backpressure: dout_ready=0 for 20 cycles while vector 3 is presented -> dout stays constant as vector 3, and rcnt does not advance.
REQ-031 SHALL cover streaming: 192 back-to-back samples with dout_ready=1 -> 24 vectors out, no overflow, and banks alternating 0, 1, 0.
REQ-032 SHALL cover overflow: 129 samples with dout_ready=0 -> sample 129 is dropped, overflow=1 and stays 1; after draining, the first vector of block 2 is 64.0..71.0.
REQ-033 SHALL cover the same-cycle case: the 64th write to bank 1 coincides with the final handshake of bank 0 -> bank 1 is FULL, bank 0 is EMPTY, and dout_valid stays 1 the next cycle showing bank 1 vector 0.
REQ-034 SHALL cover reset mid-operation: rst pulsed after 40 samples -> dout_valid=0 and overflow=0; the next 64 samples form a complete block starting at index 0.
